output_bank: RTL

- Parametrised successor to the fixed five-register IO output block. Holds NUM_CH memory-mapped output channels (LEDR, LEDG, HEXL, HEXH, LCD, ...) in the IO region of the LSU.
- Adds byte-enable writes, atomic SET/CLR/TOG aliases, one-cycle readback, and a hardware blink engine driven by a free-running prescaler.
- Sits between the LSU store path and the board pins.

---
 rtl/output_bank_if.sv | 23 ++
 rtl/output_bank.sv | 109 ++++++++++
 2 files changed

// File: rtl/output_bank_if.sv
// LSU-side bus for the output bank: address, store data/byte enables, strobes and readback.
interface output_bank_if #(
  parameter int DW = 32
);
  logic [31:0]     i_io_addr;
  logic [DW-1:0]   i_st_data;
  logic [DW/8-1:0] i_st_bmask;
  logic            f_io_wren;
  logic            f_io_rden;
  logic [DW-1:0]   o_ld_data;
  logic            o_rd_valid;
  logic            o_addr_err;

  modport master (
    output i_io_addr, i_st_data, i_st_bmask, f_io_wren, f_io_rden,
    input  o_ld_data, o_rd_valid, o_addr_err
  );

  modport slave (
    input  i_io_addr, i_st_data, i_st_bmask, f_io_wren, f_io_rden,
    output o_ld_data, o_rd_valid, o_addr_err
  );
endinterface

// File: rtl/output_bank.sv
// Memory-mapped bank of NUM_CH output channels with byte-masked SET/CLR/TOG aliases,
// one-cycle readback and a prescaler-driven blink overlay on the pins.
module output_bank #(
  parameter int          NUM_CH    = 5,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          BLINK_DIV = 25_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output_bank_if.slave         bus,
  output logic [NUM_CH*DW-1:0] b_io_out
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned CW = $clog2(BLINK_DIV);

  typedef enum logic [2:0] {
    REG_DATA  = 3'd0,
    REG_SET   = 3'd1,
    REG_CLR   = 3'd2,
    REG_TOG   = 3'd3,
    REG_BLINK = 3'd4
  } reg_e;

  logic [DW-1:0] r_data  [NUM_CH];
  logic [DW-1:0] r_blink [NUM_CH];
  logic [CW-1:0] r_cnt;
  logic          r_phase;

  logic [3:0]    w_ch;
  logic [2:0]    w_reg;
  logic          w_hit;
  logic [DW-1:0] w_bmask;
  logic [DW-1:0] w_wbits;
  logic [DW-1:0] w_rd_word;
  logic          w_unused_addr;

  assign w_ch  = bus.i_io_addr[15:12];
  assign w_reg = bus.i_io_addr[4:2];
  assign w_hit = (bus.i_io_addr[31:16] == BASE_ADDR[31:16]) &&
                 (int'({28'd0, w_ch}) < NUM_CH) &&
                 (w_reg <= REG_BLINK);
  assign w_wbits = bus.i_st_data & w_bmask;
  assign w_unused_addr = ^{bus.i_io_addr[11:5], bus.i_io_addr[1:0]};

  always_comb begin
    w_bmask = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      w_bmask[8*k +: 8] = {8{bus.i_st_bmask[k]}};
    end
  end

  // Readback uses pre-edge register values, giving read-before-write ordering.
  always_comb begin
    w_rd_word = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if ({28'd0, w_ch} == c) begin
        w_rd_word = (w_reg == REG_BLINK) ? r_blink[c] : r_data[c];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt          <= '0;
      r_phase        <= 1'b0;
      bus.o_rd_valid <= 1'b0;
      bus.o_ld_data  <= '0;
      bus.o_addr_err <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_data[c]  <= '0;
        r_blink[c] <= '0;
      end
    end else begin
      if (r_cnt == CW'(BLINK_DIV - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      bus.o_addr_err <= (bus.f_io_wren | bus.f_io_rden) & ~w_hit;
      bus.o_rd_valid <= bus.f_io_rden & w_hit;
      bus.o_ld_data  <= (bus.f_io_rden & w_hit) ? w_rd_word : '0;

      if (bus.f_io_wren && w_hit) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if ({28'd0, w_ch} == c) begin
            case (w_reg)
              REG_DATA:  r_data[c]  <= (r_data[c] & ~w_bmask) | w_wbits;
              REG_SET:   r_data[c]  <= r_data[c] | w_wbits;
              REG_CLR:   r_data[c]  <= r_data[c] & ~w_wbits;
              REG_TOG:   r_data[c]  <= r_data[c] ^ w_wbits;
              REG_BLINK: r_blink[c] <= (r_blink[c] & ~w_bmask) | w_wbits;
              default:   ;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    b_io_out = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      b_io_out[c*DW +: DW] = r_data[c] ^ (r_blink[c] & {DW{r_phase}});
    end
  end
endmodule
